// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ksa_pkg
// Purpose : Shared types and ASCII helpers for the RC4 key-search report path.
// Revision: 1.0 - initial release
// ============================================================================
package ksa_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEX    = 3'd1,
    COLON  = 3'd2,
    MSG    = 3'd3,
    CR     = 3'd4,
    LF     = 3'd5,
    FINISH = 3'd6
  } report_state_t;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    return 8'h37 + {4'h0, nibble};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_byte
// Purpose : 8N1 serialiser; frame_done marks the last cycle of the stop bit.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [3:0]         r_bit_cnt;
  logic [8:0]         r_shift;
  logic               r_active;
  logic               r_tx;
  logic               w_bit_end;

  assign w_bit_end  = (r_clk_cnt == c_cnt_w'(CLKS_PER_BIT - 1));
  // Combinational so the parent can reload on the same edge: no idle gap.
  assign frame_done = r_active && w_bit_end && (r_bit_cnt == 4'd9);
  assign tx         = r_tx;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '1;
      r_active  <= 1'b0;
      r_tx      <= 1'b1;
    end else if (load) begin
      r_tx      <= 1'b0;
      r_shift   <= {1'b1, data};
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        if (r_bit_cnt == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : msg_uart_tx
// Purpose : Reports a cracked key and its decrypted message as UART text.
// Revision: 1.0 - initial release
// ============================================================================
module msg_uart_tx
  import ksa_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MSG_LEN      = 32,
  parameter int ADDR_W       = 5,
  parameter int RD_LAT       = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [23:0]       key_found,
  output logic [ADDR_W-1:0] d_address,
  input  logic [7:0]        d_q,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int c_idx_w  = (ADDR_W + 1 < 3) ? 3 : ADDR_W + 1;
  localparam int c_pend_w = RD_LAT + 1;

  report_state_t      r_state, w_next;
  logic [c_idx_w-1:0] r_idx;
  logic [23:0]        r_key;
  logic [7:0]         r_data;
  logic [c_pend_w-1:0] r_pend;
  logic               r_done;
  logic               w_load, w_frame_done, w_issue, w_last_msg;
  logic [7:0]         w_byte;

  assign w_last_msg = (r_idx == c_idx_w'(MSG_LEN - 1));
  assign w_issue    = w_load && ((r_state == COLON) || (r_state == MSG && !w_last_msg));
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_byte = 8'hFF;
    case (r_state)
      IDLE: if (start && !r_done) w_next = HEX;
      HEX: begin
        // The first digit loads straight away; later ones wait for the frame end.
        if (w_frame_done || r_idx == '0) begin
          w_load = 1'b1;
          w_byte = hex_ascii(r_key[23:20]);
          if (r_idx == c_idx_w'(5)) w_next = COLON;
        end
      end
      COLON: if (w_frame_done) begin
        w_load = 1'b1;
        w_byte = CH_COLON;
        w_next = MSG;
      end
      MSG: if (w_frame_done) begin
        w_load = 1'b1;
        w_byte = r_data;
        if (w_last_msg) w_next = CR;
      end
      CR: if (w_frame_done) begin
        w_load = 1'b1;
        w_byte = CH_CR;
        w_next = LF;
      end
      LF: if (w_frame_done) begin
        w_load = 1'b1;
        w_byte = CH_LF;
        w_next = FINISH;
      end
      FINISH: if (w_frame_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_key     <= '0;
      r_data    <= '0;
      r_pend    <= '0;
      r_done    <= 1'b0;
      d_address <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == FINISH) && w_frame_done;
      // Read for byte n+1 goes out while byte n is on the wire.
      r_pend  <= (r_pend << 1) | c_pend_w'(w_issue);
      if (r_pend[RD_LAT]) r_data <= d_q;
      if (r_state == IDLE && w_next == HEX) begin
        r_key <= key_found;
        r_idx <= '0;
      end
      if (w_load) begin
        r_idx <= (w_next != r_state) ? '0 : r_idx + c_idx_w'(1);
        if (r_state == HEX) r_key <= {r_key[19:0], 4'h0};
      end
      if (w_issue)
        d_address <= (r_state == COLON) ? '0 : r_idx[ADDR_W-1:0] + ADDR_W'(1);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load      (w_load),
    .data      (w_byte),
    .tx        (tx),
    .frame_done(w_frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_msg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_msg_uart_tx
// Purpose : Scoreboard bench: expected frames queued at start, UART decoder checks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_msg_uart_tx;

  localparam int CPB     = 4;
  localparam int MLEN    = 32;
  localparam int AW      = 5;
  localparam int RL      = 2;
  localparam int FRAME   = 10 * CPB;
  localparam int NFRAMES = 6 + 1 + MLEN + 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [23:0]   key_found = '0;
  logic [AW-1:0] d_address;
  logic [7:0]    d_q;
  logic          tx, busy, done;

  msg_uart_tx #(.CLKS_PER_BIT(CPB), .MSG_LEN(MLEN), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .key_found(key_found),
    .d_address(d_address), .d_q(d_q), .tx(tx), .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // d_memory model with RD_LAT-cycle read pipeline
  logic [7:0]    mem [MLEN];
  logic [AW-1:0] a1 = '0, a2 = '0;
  always @(posedge CLOCK_50) begin
    a1 <= d_address;
    a2 <= a1;
  end
  assign d_q = mem[a2];

  typedef struct { logic [7:0] ch; int at; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];
  int   exp_addr[$];
  int   addr_log[$];
  int   n_checks = 0, n_fail = 0, n_reports = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [FRAME-1:0] wave_of(input logic [7:0] ch);
    logic [9:0]       bits;
    logic [FRAME-1:0] w;
    bits = {1'b1, ch, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int k = 0; k < CPB; k++) w[b*CPB + k] = bits[b];
    return w;
  endfunction

  // UART decoder: captures every cycle of a frame and compares against the queue
  initial begin : decoder
    logic [FRAME-1:0] smp;
    int   t0;
    bit   ab;
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (!reset && tx === 1'b0) begin
        t0 = cyc;
        smp[0] = tx;
        ab = 1'b0;
        check("busy_in_frame", busy, 1);
        for (int i = 1; i < FRAME; i++) begin
          @(negedge CLOCK_50);
          if (reset) ab = 1'b1;
          smp[i] = tx;
        end
        if (!ab) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: frame at cycle %0d wave %0h, required none", t0, smp);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("frame_wave_char_%0h", e.ch), smp, wave_of(e.ch));
            check("frame_start_cycle", t0, e.at);
          end
        end
      end
    end
  end

  always @(negedge CLOCK_50) begin
    if (!reset && busy && addr_log.size() > 0 && int'(d_address) != addr_log[$])
      addr_log.push_back(int'(d_address));
  end

  always @(negedge CLOCK_50) begin : done_monitor
    bit ok;
    int bad;
    if (!reset && done) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: done high at cycle %0d, required low", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
        check("busy_with_done", busy, 0);
        check("frames_left_at_done", exp_q.size(), 0);
        ok  = (addr_log.size() == exp_addr.size());
        bad = -1;
        for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
          if (bad < 0 && addr_log[i] != exp_addr[i]) bad = i;
        if (bad >= 0) ok = 1'b0;
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL addr_seq: actual %0d entries (first diff at %0d), required %0d entries",
                   addr_log.size(), bad, exp_addr.size());
        end
        n_reports++;
      end
    end
  end

  task automatic issue(input logic [23:0] key, output int c0);
    string      hd = "0123456789ABCDEF";
    exp_t       e;
    int         k, nib, guard;
    guard = 0;
    while (busy && guard < 5000) begin
      @(posedge CLOCK_50); #1;
      guard++;
    end
    if (busy) check("idle_before_start", busy, 0);
    @(posedge CLOCK_50); #1;
    start = 1'b1;
    key_found = key;
    c0 = cyc + 1;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      nib  = int'((key >> (20 - 4*i)) & 24'hF);
      e.ch = hd[nib];
      e.at = c0 + 1 + FRAME*k++;
      exp_q.push_back(e);
    end
    e.ch = 8'h3A; e.at = c0 + 1 + FRAME*k++; exp_q.push_back(e);
    for (int i = 0; i < MLEN; i++) begin
      e.ch = mem[i]; e.at = c0 + 1 + FRAME*k++; exp_q.push_back(e);
    end
    e.ch = 8'h0D; e.at = c0 + 1 + FRAME*k++; exp_q.push_back(e);
    e.ch = 8'h0A; e.at = c0 + 1 + FRAME*k++; exp_q.push_back(e);
    done_q.push_back(c0 + 1 + NFRAMES*FRAME);
    exp_addr.delete();
    addr_log.delete();
    if (d_address != '0) exp_addr.push_back(int'(d_address));
    for (int i = 0; i < MLEN; i++) exp_addr.push_back(i);
    addr_log.push_back(int'(d_address));
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    key_found = 24'($urandom);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge CLOCK_50); #1;
    end
  endtask

  task automatic wait_report(input int n_before);
    int guard;
    guard = 0;
    while (n_reports <= n_before && guard < NFRAMES*FRAME + 200) begin
      @(posedge CLOCK_50); #1;
      guard++;
    end
    check("report_completed", n_reports, n_before + 1);
  endtask

  initial begin : main
    int    c0, n0;
    string s;
    for (int i = 0; i < MLEN; i++) mem[i] = 8'h00;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", d_address, 0);
    reset = 1'b0;

    s = "the quick brown fox jumps over t";
    for (int i = 0; i < MLEN; i++) mem[i] = s[i];
    n0 = n_reports; issue(24'h0A3F7C, c0); wait_report(n0);

    // Stray starts mid-message and on the done cycle must be ignored
    for (int i = 0; i < MLEN; i++) mem[i] = 8'(i);
    n0 = n_reports; issue(24'h000000, c0);
    wait_cycle(c0 + 800);
    start = 1'b1; key_found = 24'($urandom);
    @(posedge CLOCK_50); #1; start = 1'b0;
    wait_cycle(c0 + 1 + NFRAMES*FRAME);
    start = 1'b1; key_found = 24'($urandom);
    @(posedge CLOCK_50); #1; start = 1'b0;
    repeat (60) @(posedge CLOCK_50);
    #1;
    check("busy_after_ignored_start", busy, 0);
    check("reports_after_ignored", n_reports, n0 + 1);

    for (int i = 0; i < MLEN; i++) mem[i] = 8'($urandom);
    n0 = n_reports; issue(24'hFFFFFF, c0); wait_report(n0);
    for (int i = 0; i < MLEN; i++) mem[i] = 8'($urandom);
    n0 = n_reports; issue(24'h9ABCDE, c0); wait_report(n0);

    // Asynchronous reset during the start bit of frame 10
    for (int i = 0; i < MLEN; i++) mem[i] = 8'($urandom);
    issue(24'($urandom), c0);
    wait_cycle(c0 + 1 + 10*FRAME);
    #1 reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", d_address, 0);
    check("async_rst_done", done, 0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    repeat (50) @(posedge CLOCK_50);
    #1;
    check("idle_tx_after_rst", tx, 1);
    n0 = n_reports; issue(24'($urandom), c0); wait_report(n0);
    check("reports_total", n_reports, 5);

    repeat (20) @(posedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
